evrisim_paketleyici: RTL and testbench



---
 rtl/evrisim_paketleyici.sv | 137 +++++++++++++
 tb/tb_evrisim_paketleyici.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/evrisim_paketleyici.sv
// evrisim_paketleyici
// Packs a stream of 8-bit convolution results into little-endian 32-bit
// words and buffers them in a first-word-fall-through FIFO for a
// valid/ready consumer. The word holding the last pixel of a frame carries
// a son (last) flag, and its transfer raises a one-cycle frame-done pulse.
// The upstream stage cannot be stalled. If a word arrives while the FIFO is
// full and nothing leaves on that edge, the word is dropped and a sticky
// overflow flag is set. Pixel counting continues, so frame alignment holds.
//
// Optional build macro: PAKETLEYICI_DUSEN_SAYAC_EN adds dusen_sayisi_o, a
// saturating count of dropped words.
//
// Ports
//   clk_i            clock, rising edge
//   rstn_i           synchronous active-low reset
//   veri_etkin_i     pixel strobe (no backpressure)
//   veri_i[7:0]      pixel value
//   paket_gecerli_o  FIFO head valid
//   paket_o[31:0]    FIFO head word, pixel n in bits [8n+7:8n]
//   son_paket_o      head word is the last word of a frame
//   paket_hazir_i    downstream ready
//   cerceve_bitti_o  pulse on the cycle after the last word transfers
//   tasma_o          sticky overflow flag
//   dusen_sayisi_o   dropped-word count (macro builds only)
module evrisim_paketleyici #(
  parameter int FIFO_DERINLIK = 8,
  parameter int PIKSEL_SAYISI = 76800
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        veri_etkin_i,
  input  logic [7:0]  veri_i,
  output logic        paket_gecerli_o,
  output logic [31:0] paket_o,
  output logic        son_paket_o,
  input  logic        paket_hazir_i,
  output logic        cerceve_bitti_o,
  output logic        tasma_o
`ifdef PAKETLEYICI_DUSEN_SAYAC_EN
  ,
  output logic [15:0] dusen_sayisi_o
`endif
);

  localparam int AW = $clog2(FIFO_DERINLIK);
  localparam int PW = $clog2(PIKSEL_SAYISI);
  localparam logic [AW:0]   DOLU       = (AW+1)'(FIFO_DERINLIK);
  localparam logic [PW-1:0] SON_PIKSEL = PW'(PIKSEL_SAYISI - 1);

  typedef enum logic [1:0] {BOSTA, AKTIF, BOSALT} durum_t;
  durum_t durum, durum_sonraki;

  logic [1:0]    bayt_idx;
  logic [23:0]   kismi;      // first three pixels of the word being built
  logic [PW-1:0] piksel;
  logic [32:0]   bellek [FIFO_DERINLIK];  // {son, word}
  logic [AW-1:0] oku, yaz;
  logic [AW:0]   doluluk;
  logic          itme, cekme, kabul, dusur, son_piksel, son_dustu;

  assign son_piksel = (piksel == SON_PIKSEL);
  assign itme       = veri_etkin_i && (bayt_idx == 2'd3);
  assign cekme      = paket_gecerli_o && paket_hazir_i;
  // A full FIFO can still take the word when the head leaves on the same
  // edge: the slot being written is the one being vacated.
  assign kabul      = itme && ((doluluk != DOLU) || cekme);
  assign dusur      = itme && !kabul;

  assign paket_gecerli_o = (doluluk != '0);
  assign paket_o         = paket_gecerli_o ? bellek[oku][31:0] : '0;
  assign son_paket_o     = paket_gecerli_o && bellek[oku][32];

  // PIKSEL_SAYISI is a multiple of 4, so pixel N-1 is always byte 3 and
  // son_piksel is valid whenever a word is pushed.
  always_ff @(posedge clk_i) begin
    if (rstn_i && kabul) bellek[yaz] <= {son_piksel, veri_i, kismi};
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      bayt_idx        <= '0;
      kismi           <= '0;
      piksel          <= '0;
      oku             <= '0;
      yaz             <= '0;
      doluluk         <= '0;
      tasma_o         <= 1'b0;
      cerceve_bitti_o <= 1'b0;
      son_dustu       <= 1'b0;
    end else begin
      cerceve_bitti_o <= cekme && son_paket_o;
      son_dustu       <= dusur && son_piksel;
      if (veri_etkin_i) begin
        bayt_idx <= bayt_idx + 2'd1;
        // New pixels enter at the top, so pixel 0 ends up in the low byte.
        kismi    <= {veri_i, kismi[23:8]};
        piksel   <= son_piksel ? '0 : piksel + 1'b1;
      end
      if (kabul) yaz <= yaz + 1'b1;
      if (cekme) oku <= oku + 1'b1;
      case ({kabul, cekme})
        2'b10:   doluluk <= doluluk + 1'b1;
        2'b01:   doluluk <= doluluk - 1'b1;
        default: doluluk <= doluluk;
      endcase
      if (dusur) tasma_o <= 1'b1;
    end
  end

  // Frame tracker. Output timing does not depend on it; it records where
  // the packer is within a frame.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) durum <= BOSTA;
    else         durum <= durum_sonraki;
  end

  always_comb begin
    durum_sonraki = durum;
    case (durum)
      BOSTA:  if (veri_etkin_i) durum_sonraki = AKTIF;
      AKTIF:  if (itme && son_piksel) durum_sonraki = BOSALT;
      BOSALT: begin
        if (veri_etkin_i)                            durum_sonraki = AKTIF;
        else if (son_dustu || (cekme && son_paket_o)) durum_sonraki = BOSTA;
      end
      default: durum_sonraki = BOSTA;
    endcase
  end

`ifdef PAKETLEYICI_DUSEN_SAYAC_EN
  always_ff @(posedge clk_i) begin
    if (!rstn_i)                                 dusen_sayisi_o <= '0;
    else if (dusur && dusen_sayisi_o != 16'hFFFF) dusen_sayisi_o <= dusen_sayisi_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_evrisim_paketleyici.sv
module tb_evrisim_paketleyici;
  localparam int D = 8;
  localparam int N = 64;  // short frame keeps two-frame runs brief

  logic        clk = 1'b0;
  logic        rstn, etkin, hazir;
  logic [7:0]  veri;
  logic        gecerli, son, bitti, tasma;
  logic [31:0] paket;
`ifdef PAKETLEYICI_DUSEN_SAYAC_EN
  logic [15:0] dusen;
`endif

  evrisim_paketleyici #(.FIFO_DERINLIK(D), .PIKSEL_SAYISI(N)) dut (
    .clk_i(clk), .rstn_i(rstn), .veri_etkin_i(etkin), .veri_i(veri),
    .paket_gecerli_o(gecerli), .paket_o(paket), .son_paket_o(son),
    .paket_hazir_i(hazir), .cerceve_bitti_o(bitti), .tasma_o(tasma)
`ifdef PAKETLEYICI_DUSEN_SAYAC_EN
    , .dusen_sayisi_o(dusen)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int xfers = 0, pulses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pixels gather in groups of four; each group becomes
  // one word whose byte n is pixel n. A word is kept when the buffer (after
  // this cycle's departure) has room. The last pixel of every N-pixel
  // frame marks its word as last.
  typedef struct { logic [31:0] d; logic son; } ent_t;
  ent_t        mq[$];
  logic [7:0]  pbuf[$];
  longint      pix_tot;
  logic        m_tasma, m_bitti;
  int          m_drop;

  always @(posedge clk) begin
    if (!rstn) begin
      mq.delete(); pbuf.delete();
      pix_tot = 0; m_tasma = 0; m_bitti = 0; m_drop = 0;
    end else begin
      logic popped;
      popped  = (mq.size() > 0) && hazir;
      m_bitti = popped && mq[0].son;
      if (popped) void'(mq.pop_front());
      if (etkin) begin
        logic son_p;
        son_p = (pix_tot % N) == N - 1;
        pix_tot++;
        pbuf.push_back(veri);
        if (pbuf.size() == 4) begin
          ent_t e;
          e.d = {pbuf[3], pbuf[2], pbuf[1], pbuf[0]};
          e.son = son_p;
          pbuf.delete();
          if (mq.size() < D) mq.push_back(e);
          else begin
            m_tasma = 1;
            if (m_drop < 16'hFFFF) m_drop++;
          end
        end
      end
    end
  end

  // Monitor: mid-cycle, compares the presented head and status flags with
  // the model and counts transfers and frame pulses seen on the DUT pins.
  always @(negedge clk) begin
    chk("valid", {31'd0, gecerli}, {31'd0, mq.size() != 0});
    if (mq.size() != 0) begin
      chk("word", paket, mq[0].d);
      chk("son", {31'd0, son}, {31'd0, mq[0].son});
    end
    chk("tasma", {31'd0, tasma}, {31'd0, m_tasma});
    chk("bitti", {31'd0, bitti}, {31'd0, m_bitti});
`ifdef PAKETLEYICI_DUSEN_SAYAC_EN
    chk("dusen", {16'd0, dusen}, m_drop);
`endif
    if (gecerli && hazir) xfers++;
    if (bitti) pulses++;
  end

  task automatic cyc(input logic e, input logic [7:0] v, input logic r);
    etkin = e; veri = v; hazir = r;
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    rstn = 0; etkin = 0; hazir = 0; veri = 0;
    repeat (n) begin @(posedge clk); #1; end
    rstn = 1;
  endtask

  int x0, p0;

  initial begin
    do_reset(2);
    chk("rst_valid", {31'd0, gecerli}, 0);
    chk("rst_paket", paket, 0);
    chk("rst_son", {31'd0, son}, 0);
    chk("rst_bitti", {31'd0, bitti}, 0);
    chk("rst_tasma", {31'd0, tasma}, 0);

    // Basic packing and first-word latency.
    cyc(1, 8'h11, 1); cyc(1, 8'h22, 1); cyc(1, 8'h33, 1); cyc(1, 8'h44, 1);
    chk("basic_valid", {31'd0, gecerli}, 1);
    chk("basic_word", paket, 32'h44332211);
    repeat (3) cyc(0, 0, 1);

    // Full FIFO with a pop on the same edge as the push: no overflow.
    do_reset(1);
    repeat (32) cyc(1, 8'($urandom), 0);
    repeat (3) cyc(1, 8'($urandom), 0);
    cyc(1, 8'($urandom), 1);
    chk("fullpop_tasma", {31'd0, tasma}, 0);
    x0 = xfers;
    repeat (12) cyc(0, 0, 1);
    chk("fullpop_occ", xfers - x0, 8);

    // Overflow: nine words into an 8-deep FIFO, then drain.
    do_reset(1);
    repeat (36) cyc(1, 8'($urandom), 0);
    chk("ovf_tasma", {31'd0, tasma}, 1);
`ifdef PAKETLEYICI_DUSEN_SAYAC_EN
    chk("ovf_dusen", {16'd0, dusen}, 1);
`endif
    x0 = xfers;
    repeat (12) cyc(0, 0, 1);
    chk("ovf_drain", xfers - x0, 8);
    chk("ovf_sticky", {31'd0, tasma}, 1);

    // Reset in mid-frame discards the partial word.
    do_reset(1);
    repeat (6) cyc(1, 8'($urandom), 0);
    do_reset(1);
    cyc(1, 8'hA0, 0); cyc(1, 8'hA1, 0); cyc(1, 8'hA2, 0); cyc(1, 8'hA3, 0);
    chk("midrst_word", paket, 32'hA3A2A1A0);
    chk("midrst_tasma", {31'd0, tasma}, 0);
    repeat (3) cyc(0, 0, 1);

    // Two back-to-back frames, ready toggling every cycle.
    do_reset(1);
    x0 = xfers; p0 = pulses;
    for (int i = 0; i < 2 * N; i++) cyc(1, 8'($urandom), i[0]);
    repeat (24) cyc(0, 0, 1);
    chk("frames_words", xfers - x0, 2 * N / 4);
    chk("frames_pulses", pulses - p0, 2);
    chk("frames_tasma", {31'd0, tasma}, 0);

    // Random traffic, including overflow.
    do_reset(1);
    for (int i = 0; i < 800; i++)
      cyc(1'($urandom_range(0, 9) < 6), 8'($urandom), 1'($urandom_range(0, 9) < 4));
    repeat (12) cyc(0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
